// File: rtl/tri_mask_pkg.sv
// Shared types and helpers for the triangular mask sequencer.
// The op encoding gives the fill direction in bit 0 and the drain flag in bit 1.
package tri_mask_pkg;

  typedef enum logic [1:0] {
    FILL_L         = 2'b00,
    FILL_R         = 2'b01,
    FILL_L_DRAIN_R = 2'b10,
    FILL_R_DRAIN_L = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    FIRST   = 3'd2,
    PRESENT = 3'd3,
    DONE    = 3'd4
  } state_e;

  function automatic logic is_drain_op(input op_e op);
    return (op == FILL_L_DRAIN_R) || (op == FILL_R_DRAIN_L);
  endfunction

  // The fill phase shifts right when ones enter from the MSB side.
  function automatic logic fill_dir_right(input op_e op);
    return (op == FILL_R) || (op == FILL_R_DRAIN_L);
  endfunction

endpackage

// File: rtl/triangular_mask_sequencer.sv
// Control FSM driving a bidirectional mask shift register through fill
// (and optional drain) thermometer sequences, one step per handshake.
module triangular_mask_sequencer
  import tri_mask_pkg::*;
#(
  parameter int N     = 5,
  parameter int IDX_W = $clog2(2*N-1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             step_valid,
  input  logic             step_ready,
  output logic [IDX_W-1:0] step_idx,
  output logic             step_last,
  output logic             sr_shift_in,
  output logic             sr_direction_right,
  output logic             sr_reset_zero,
  output logic             sr_shift
);

  localparam logic [IDX_W-1:0] LAST_FILL  = IDX_W'(N-1);
  localparam logic [IDX_W-1:0] LAST_DRAIN = IDX_W'(2*N-2);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [IDX_W-1:0] last_idx;
  logic             in_present;
  logic             in_first;
  logic             last_step;
  logic             next_is_fill;
  logic             fill_dir;

  always_comb begin
    in_present   = (state_q == PRESENT);
    in_first     = (state_q == FIRST);
    last_idx     = is_drain_op(op_q) ? LAST_DRAIN : LAST_FILL;
    last_step    = in_present && (idx_q == last_idx);
    // The shift issued from PRESENT builds step idx_q+1.
    next_is_fill = (idx_q < LAST_FILL);
    fill_dir     = fill_dir_right(op_q);
  end

  // Status and step outputs come from registered state only.
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign step_valid = in_present;
  assign step_idx   = in_present ? idx_q : '0;
  assign step_last  = last_step;

  // Register controls; abort clears the mask and suppresses any shift.
  always_comb begin
    sr_reset_zero      = (state_q == CLEAR) || (abort && (state_q != IDLE));
    sr_shift           = !abort && (in_first || (in_present && step_ready && !last_step));
    sr_shift_in        = in_first || (in_present && next_is_fill);
    sr_direction_right = 1'b0;
    if (in_first) begin
      sr_direction_right = fill_dir;
    end else if (in_present) begin
      sr_direction_right = next_is_fill ? fill_dir : !fill_dir;
    end
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = CLEAR;
          op_d    = op_e'(op);
          idx_d   = '0;
        end
      end
      CLEAR: begin
        state_d = abort ? IDLE : FIRST;
      end
      FIRST: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d = PRESENT;
          idx_d   = '0;
        end
      end
      PRESENT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (step_ready) begin
          if (last_step) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= FILL_L;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
    end
  end

endmodule
